// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the frequency meter counting path.
// BCD digit width, state encoding and result-width function.
package freq_meas_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  function automatic int bcd_w(input int digits);
    return BCD_W * digits;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD counter cell: 0..9 with a combinational carry out.
// load restarts the cell at 0, or at 1 when inc is high in the same cycle.
module bcd_digit
  import freq_meas_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic at_max;

  assign at_max = (q == BCD_MAX);
  assign carry  = inc & at_max;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= {{(BCD_W-1){1'b0}}, inc};
    end else if (inc) begin
      q <= at_max ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_window_counter.sv
// N-digit BCD event counter gated by a window level.
// Latches the count and overflow flag when the window closes.
module bcd_window_counter
  import freq_meas_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     counter_en,
  input  logic                     gate,
  input  logic                     clr,
  output logic [bcd_w(DIGITS)-1:0] out,
  output logic                     overflow,
  output logic                     valid,
  output logic                     busy
);

  localparam int W = bcd_w(DIGITS);

  state_t            state;
  logic              gate_q;
  logic              ovf_run;
  logic              rise;
  logic              fall;
  logic              load;
  logic              hit;
  logic              all9;
  logic              step;
  logic              ovf_hit;
  logic [W-1:0]      count;
  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] nines;

  assign rise  = gate & ~gate_q;
  assign fall  = ~gate & gate_q;
  assign load  = (state == IDLE) & rise & ~clr;
  assign hit   = (state == COUNT) & gate & counter_en & ~clr;
  assign all9  = &nines;
  assign step  = hit & ~(SATURATE & all9);
  assign busy  = (state == COUNT);

  assign chain[0] = load ? counter_en : step;

  // In saturate mode the chain is stalled, so detect the all-9s event directly
  assign ovf_hit = SATURATE ? (hit & all9) : chain[DIGITS];

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_lsd
      assign inc[k] = chain[0];
    end else begin : g_upper
      assign inc[k] = chain[k] & ~load;
    end

    assign nines[k] = (count[k*BCD_W +: BCD_W] == BCD_MAX);

    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .load  (load),
      .inc   (inc[k]),
      .q     (count[k*BCD_W +: BCD_W]),
      .carry (chain[k+1])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      gate_q   <= 1'b0;
      ovf_run  <= 1'b0;
      out      <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      gate_q <= gate;
      valid  <= 1'b0;
      if (clr) begin
        state   <= IDLE;
        ovf_run <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              state   <= COUNT;
              ovf_run <= 1'b0;
            end
          end
          COUNT: begin
            if (fall) begin
              state    <= IDLE;
              out      <= count;
              overflow <= ovf_run;
              valid    <= 1'b1;
            end else if (ovf_hit) begin
              ovf_run <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
